// File: rtl/cpu_axil_bridge_if.sv
// AXI4-Lite bus bundle used between cpu_axil_bridge (master) and a peripheral.
// Parameters : ADDR_W address width, DATA_W data width (<=64).
// Modports   : master - drives AW/W/AR channels and B/R ready
//              slave  - drives AW/W/AR ready, B response and R data
interface cpu_axil_bridge_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m_awaddr;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;
  logic [ADDR_W-1:0]   m_araddr;
  logic                m_arvalid;
  logic                m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rvalid;
  logic                m_rready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid,
           m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid,
           m_arready, m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/cpu_axil_bridge.sv
// cpu_axil_bridge: converts the CPU data-memory level handshake
// (cpu_addr_valid / cpu_ready) into single AXI4-Lite transactions, one at a time.
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   cpu_addr_valid  request, held until cpu_ready; cpu_rw 1=write 0=read
//   cpu_addr/wdata  64-bit request fields, low ADDR_W/DATA_W bits forwarded
//   cpu_rdata       read data (zero-extended), holds until the next read completes
//   cpu_ready/err   completion and bad-response/timeout flag
//   m               AXI4-Lite master modport
// Optional feature: define BRIDGE_TIMEOUT_EN to abort a transaction that has
// been waiting on the slave for TIMEOUT_CYCLES cycles.
module cpu_axil_bridge #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_addr_valid,
  input  logic        cpu_rw,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic [63:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  cpu_axil_bridge_if.master m
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t state;
  logic   aw_done, w_done;
  logic   aw_hs, w_hs, tmo_hit;

  // Upper request bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{cpu_addr, cpu_wdata};

  assign m.m_wstrb = '1;
  assign aw_hs = m.m_awvalid && m.m_awready;
  assign w_hs  = m.m_wvalid && m.m_wready;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt;

  // Counts cycles spent waiting on the slave; cleared while idle.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state == DONE) tmo_cnt <= '0;
    else                                       tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state != IDLE) && (state != DONE) &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      m.m_awaddr  <= '0;
      m.m_awvalid <= 1'b0;
      m.m_wdata   <= '0;
      m.m_wvalid  <= 1'b0;
      m.m_bready  <= 1'b0;
      m.m_araddr  <= '0;
      m.m_arvalid <= 1'b0;
      m.m_rready  <= 1'b0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      cpu_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cpu_addr_valid) begin
          if (cpu_rw) begin
            m.m_awaddr  <= cpu_addr[ADDR_W-1:0];
            m.m_wdata   <= cpu_wdata[DATA_W-1:0];
            m.m_awvalid <= 1'b1;
            m.m_wvalid  <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            state       <= WR;
          end else begin
            m.m_araddr  <= cpu_addr[ADDR_W-1:0];
            m.m_arvalid <= 1'b1;
            state       <= RD_ADDR;
          end
        end
        // AW and W complete independently; move on once both have landed,
        // including the case where the last one lands this cycle.
        WR: begin
          if (aw_hs) begin
            m.m_awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            m.m_wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m.m_bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: if (m.m_bvalid) begin
          m.m_bready <= 1'b0;
          cpu_ready  <= 1'b1;
          cpu_err    <= (m.m_bresp != 2'b00);
          state      <= DONE;
        end
        RD_ADDR: if (m.m_arready) begin
          m.m_arvalid <= 1'b0;
          m.m_rready  <= 1'b1;
          state       <= RD_DATA;
        end
        RD_DATA: if (m.m_rvalid) begin
          m.m_rready <= 1'b0;
          cpu_rdata  <= 64'(m.m_rdata);
          cpu_err    <= (m.m_rresp != 2'b00);
          cpu_ready  <= 1'b1;
          state      <= DONE;
        end
        // Stay here until the CPU drops its request so one request
        // never launches two bus transactions.
        DONE: if (!cpu_addr_valid) begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Abort overrides whatever the slave did this cycle.
      if (tmo_hit) begin
        m.m_awvalid <= 1'b0;
        m.m_wvalid  <= 1'b0;
        m.m_bready  <= 1'b0;
        m.m_arvalid <= 1'b0;
        m.m_rready  <= 1'b0;
        cpu_ready   <= 1'b1;
        cpu_err     <= 1'b1;
        if (state == RD_ADDR || state == RD_DATA) cpu_rdata <= '0;
        state       <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_cpu_axil_bridge.sv
// Self-checking bench for cpu_axil_bridge: table of transactions against a
// delay-configurable AXI4-Lite slave, scoreboard of expected completions,
// plus hand-written reset and (with BRIDGE_TIMEOUT_EN) timeout sequences.
module tb_cpu_axil_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_addr_valid;
  logic        cpu_rw;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic [63:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;

  cpu_axil_bridge_if #(.ADDR_W(4), .DATA_W(32)) axi ();

  cpu_axil_bridge #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_addr_valid (cpu_addr_valid),
    .cpu_rw         (cpu_rw),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ready      (cpu_ready),
    .cpu_err        (cpu_err),
    .m              (axi.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- slave model ----------------
  int          cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
  logic [1:0]  cfg_resp;
  logic [31:0] cfg_rdata;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [3:0]  cap_awaddr, cap_araddr;
  logic [31:0] cap_wdata;

  // Readies/valids change on the falling edge, away from the DUT's edge.
  always @(negedge clk) begin
    if (!axi.m_awvalid) begin axi.m_awready = 1'b0; aw_cnt = 0; end
    else if (aw_cnt >= cfg_aw_dly) axi.m_awready = 1'b1;
    else aw_cnt++;
    if (!axi.m_wvalid) begin axi.m_wready = 1'b0; w_cnt = 0; end
    else if (w_cnt >= cfg_w_dly) axi.m_wready = 1'b1;
    else w_cnt++;
    if (!axi.m_arvalid) begin axi.m_arready = 1'b0; ar_cnt = 0; end
    else if (ar_cnt >= cfg_ar_dly) axi.m_arready = 1'b1;
    else ar_cnt++;
    if (!axi.m_bready) begin axi.m_bvalid = 1'b0; b_cnt = 0; end
    else if (!axi.m_bvalid) begin
      if (b_cnt >= cfg_b_dly) axi.m_bvalid = 1'b1; else b_cnt++;
    end
    if (!axi.m_rready) begin axi.m_rvalid = 1'b0; r_cnt = 0; end
    else if (!axi.m_rvalid) begin
      if (r_cnt >= cfg_r_dly) axi.m_rvalid = 1'b1; else r_cnt++;
    end
    axi.m_bresp = cfg_resp;
    axi.m_rresp = cfg_resp;
    axi.m_rdata = cfg_rdata;
  end

  always @(posedge clk) begin
    if (axi.m_awvalid && axi.m_awready) begin aw_hs++; cap_awaddr = axi.m_awaddr; end
    if (axi.m_wvalid && axi.m_wready) begin w_hs++; cap_wdata = axi.m_wdata; end
    if (axi.m_arvalid && axi.m_arready) begin ar_hs++; cap_araddr = axi.m_araddr; end
    if (axi.m_bvalid && axi.m_bready) b_hs++;
    if (axi.m_rvalid && axi.m_rready) r_hs++;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          hold;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [63:0] rdata;
    logic        err;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];

  function automatic vec_t mk(input logic rw, input logic [63:0] addr, input logic [63:0] wdata,
                              input int aw, input int w, input int b, input int ar, input int r,
                              input logic [1:0] resp, input logic [31:0] rdata, input int hold,
                              input logic [63:0] erd, input logic eerr, input logic [3:0] eaddr,
                              input logic [31:0] ewd);
    vec_t v;
    v.rw = rw; v.addr = addr; v.wdata = wdata;
    v.aw_dly = aw; v.w_dly = w; v.b_dly = b; v.ar_dly = ar; v.r_dly = r;
    v.resp = resp; v.rdata = rdata; v.hold = hold;
    v.exp_rdata = erd; v.exp_err = eerr; v.exp_addr = eaddr; v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic set_cfg(input vec_t v);
    cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly;
    cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly;
    cfg_resp = v.resp; cfg_rdata = v.rdata;
  endtask

  task automatic run(input vec_t v);
    int   aw0, w0, b0, ar0, r0, cyc;
    exp_t e;
    set_cfg(v);
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
    cpu_rw = v.rw; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_addr_valid = 1'b1;
    sb.push_back('{v.rw, v.exp_rdata, v.exp_err, v.exp_addr, v.exp_wdata});
    cyc = 0;
    while (!cpu_ready && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    e = sb.pop_front();
    chk("ready_seen", 64'(cpu_ready), 64'd1);
    chk("cpu_rdata", cpu_rdata, e.rdata);
    chk("cpu_err", 64'(cpu_err), 64'(e.err));
    if (e.rw) begin
      chk("aw_count", 64'(aw_hs - aw0), 64'd1);
      chk("w_count", 64'(w_hs - w0), 64'd1);
      chk("b_count", 64'(b_hs - b0), 64'd1);
      chk("awaddr", 64'(cap_awaddr), 64'(e.addr));
      chk("wdata", 64'(cap_wdata), 64'(e.wdata));
      chk("no_ar", 64'(ar_hs - ar0), 64'd0);
    end else begin
      chk("ar_count", 64'(ar_hs - ar0), 64'd1);
      chk("r_count", 64'(r_hs - r0), 64'd1);
      chk("araddr", 64'(cap_araddr), 64'(e.addr));
      chk("no_aw", 64'(aw_hs - aw0), 64'd0);
    end
    if (v.hold > 0) begin
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk); #1;
      end
      chk("hold_ready", 64'(cpu_ready), 64'd1);
      chk("hold_no_extra", 64'((aw_hs - aw0) + (ar_hs - ar0)), 64'd1);
      chk("hold_valids", 64'({axi.m_awvalid, axi.m_wvalid, axi.m_arvalid}), 64'd0);
    end
    cpu_addr_valid = 1'b0;
    @(posedge clk); #1;
    chk("release_ready", 64'(cpu_ready), 64'd0);
    chk("release_err", 64'(cpu_err), 64'd0);
    chk("rdata_hold", cpu_rdata, e.rdata);
  endtask

  initial begin
    int   cyc;
    vec_t v;
    rst = 1'b1; cpu_addr_valid = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
    cfg_resp = 2'b00; cfg_rdata = '0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;

    //          rw addr                    wdata                  aw w b ar r resp   rdata         hold exp_rdata      err addr wdata
    tbl[0] = mk(1, 64'h4,                  64'h48,                3, 0, 0, 0, 0, 2'b00, 32'h0,        0, 64'h0,          0, 4'h4, 32'h48);
    tbl[1] = mk(0, 64'h8,                  64'h0,                 0, 0, 0, 0, 0, 2'b00, 32'h15,       0, 64'h15,         0, 4'h8, 32'h0);
    tbl[2] = mk(1, 64'hC,                  64'hDEADBEEF,          0, 2, 1, 0, 0, 2'b10, 32'h0,        5, 64'h15,         1, 4'hC, 32'hDEADBEEF);
    tbl[3] = mk(0, 64'h1,                  64'h0,                 0, 0, 0, 2, 3, 2'b11, 32'hFFFFFFFF, 0, 64'hFFFFFFFF,   1, 4'h1, 32'h0);
    tbl[4] = mk(1, 64'hFFFFFFFFFFFFFFF7,   64'h123456789ABCDEF0,  1, 1, 3, 0, 0, 2'b01, 32'h0,        0, 64'hFFFFFFFF,   1, 4'h7, 32'h9ABCDEF0);
    tbl[5] = mk(0, 64'h23,                 64'h0,                 0, 0, 0, 0, 0, 2'b00, 32'hA5A50001, 2, 64'hA5A50001,   0, 4'h3, 32'h0);
    tbl[6] = mk(1, 64'h2,                  64'h77,                0, 0, 0, 0, 0, 2'b00, 32'h0,        0, 64'h0,          0, 4'h2, 32'h77);

    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({cpu_ready, cpu_err, axi.m_awvalid, axi.m_wvalid, axi.m_bready,
                           axi.m_arvalid, axi.m_rready}), 64'd0);
    chk("reset_rdata", cpu_rdata, 64'd0);
    chk("reset_addr_data", 64'({axi.m_awaddr, axi.m_araddr, axi.m_wdata}), 64'd0);
    chk("wstrb", 64'(axi.m_wstrb), 64'hF);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Reset while waiting for the write response.
    v = tbl[6];
    v.b_dly = 50;
    set_cfg(v);
    cpu_rw = 1'b1; cpu_addr = 64'h5; cpu_wdata = 64'h99; cpu_addr_valid = 1'b1;
    cyc = 0;
    while (!axi.m_bready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("reach_wr_resp", 64'(axi.m_bready), 64'd1);
    rst = 1'b1; cpu_addr_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ctrl", 64'({cpu_ready, cpu_err, axi.m_awvalid, axi.m_wvalid, axi.m_bready,
                             axi.m_arvalid, axi.m_rready}), 64'd0);
    chk("rst_mid_rdata", cpu_rdata, 64'd0);
    chk("rst_mid_addr_data", 64'({axi.m_awaddr, axi.m_araddr, axi.m_wdata}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run(tbl[6]);

`ifdef BRIDGE_TIMEOUT_EN
    // Read against a slave that never accepts the address.
    v = tbl[5];
    v.ar_dly = 100000;
    set_cfg(v);
    cpu_rw = 1'b0; cpu_addr = 64'h6; cpu_addr_valid = 1'b1;
    cyc = 0;
    while (!cpu_ready && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    chk("tmo_ready", 64'(cpu_ready), 64'd1);
    chk("tmo_latency_le17", 64'(cyc <= 17), 64'd1);
    chk("tmo_err", 64'(cpu_err), 64'd1);
    chk("tmo_rdata", cpu_rdata, 64'd0);
    chk("tmo_arvalid", 64'(axi.m_arvalid), 64'd0);
    cpu_addr_valid = 1'b0;
    @(posedge clk); #1;
    chk("tmo_release", 64'({cpu_ready, cpu_err}), 64'd0);
    run(tbl[1]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
